// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes.
// Define ILLEGAL_TRAP_EN to park illegal instructions in a sticky TRAP state; otherwise they retire as NOPs.
module multicycle_control #(
    parameter int WIDTH      = 32,
    parameter int ALU_CTRL_W = 3,
    parameter int RET_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      instr,
    input  logic                  EQ,
    input  logic                  imem_ack,
    input  logic                  dmem_ack,
    output logic                  imem_req,
    output logic                  dmem_req,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  PCsrc,
    output logic                  RegWrite,
    output logic                  ALUsrc,
    output logic [ALU_CTRL_W-1:0] ALUctrl,
    output logic [1:0]            ImmSrc,
    output logic                  ResultSrc,
    output logic [RET_W-1:0]      retired,
    output logic                  illegal
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    localparam logic [6:0] OPC_IMM = 7'd19, OPC_OP = 7'd51, OPC_BR = 7'd99,
                           OPC_LD  = 7'd3,  OPC_ST = 7'd35;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_SLT = 3'b101;

    state_t           state_q, state_d;
    logic [RET_W-1:0] ret_q, ret_d;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    assign opc = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // Register/immediate fields feed the datapath only.
    logic unused_fields;
    assign unused_fields = ^instr[24:15];
    if (WIDTH > 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^instr[WIDTH-1:32];
    end

    logic f3_alu, is_opi, is_op, is_br, is_lw, is_sw, legal;
    logic [2:0] alu_f;
    assign f3_alu = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    assign is_opi = (opc == OPC_IMM) && f3_alu;
    assign is_op  = (opc == OPC_OP) && (((f7 == 7'b0000000) && f3_alu) ||
                                        ((f7 == 7'b0100000) && (f3 == 3'b000)));
    assign is_br  = (opc == OPC_BR) && (f3[2:1] == 2'b00);
    assign is_lw  = (opc == OPC_LD) && (f3 == 3'b010);
    assign is_sw  = (opc == OPC_ST) && (f3 == 3'b010);
    assign legal  = is_opi | is_op | is_br | is_lw | is_sw;

    always_comb begin
        alu_f = ALU_ADD;
        case (f3)
            3'b000:  alu_f = (is_op && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_f = ALU_AND;
            3'b110:  alu_f = ALU_OR;
            3'b010:  alu_f = ALU_SLT;
            default: alu_f = ALU_ADD;
        endcase
    end

    logic       c_ireq, c_dreq, c_mw, c_irw, c_pcw, c_pcs, c_rw, c_asrc, c_rs;
    logic [2:0] c_alu;
    logic [1:0] c_imm;

    always_comb begin
        state_d = state_q;
        c_ireq  = 1'b0;
        c_dreq  = 1'b0;
        c_mw    = 1'b0;
        c_irw   = 1'b0;
        c_pcw   = 1'b0;
        c_pcs   = 1'b0;
        c_rw    = 1'b0;
        c_asrc  = 1'b0;
        c_rs    = 1'b0;
        c_alu   = ALU_ADD;
        c_imm   = 2'b00;
        case (state_q)
            S_FETCH: begin
                c_ireq = 1'b1;
                if (imem_ack) begin
                    c_irw   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    c_pcw   = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    c_alu   = ALU_SUB;
                    c_imm   = 2'b10;
                    c_pcw   = 1'b1;
                    c_pcs   = f3[0] ? ~EQ : EQ;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    c_alu   = ALU_ADD;
                    c_asrc  = 1'b1;
                    c_imm   = is_sw ? 2'b01 : 2'b00;
                    state_d = S_MEM;
                end else begin
                    c_alu   = alu_f;
                    c_asrc  = is_opi;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                c_dreq = 1'b1;
                c_mw   = is_sw;
                if (dmem_ack) begin
                    c_pcw   = is_sw;
                    state_d = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                c_rw    = (rd != 5'd0);
                c_rs    = is_lw;
                c_pcw   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Gating with rst lets an asynchronous reset drop every strobe in the same cycle.
    assign imem_req  = rst & c_ireq;
    assign dmem_req  = rst & c_dreq;
    assign MemWrite  = rst & c_mw;
    assign IRWrite   = rst & c_irw;
    assign PCWrite   = rst & c_pcw;
    assign PCsrc     = rst & c_pcs;
    assign RegWrite  = rst & c_rw;
    assign ALUsrc    = rst & c_asrc;
    assign ResultSrc = rst & c_rs;
    assign ALUctrl   = rst ? ALU_CTRL_W'(c_alu) : '0;
    assign ImmSrc    = rst ? c_imm : 2'b00;

    assign ret_d   = c_pcw ? ret_q + RET_W'(1) : ret_q;
    assign retired = ret_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected cycle traces built from the ISA rules.
module tb_multicycle_control;
    localparam int RET_W = 4;

    logic clk = 1'b0;
    logic rst, EQ, imem_ack, dmem_ack;
    logic [31:0] instr;
    logic imem_req, dmem_req, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, ResultSrc, illegal;
    logic [2:0] ALUctrl;
    logic [1:0] ImmSrc;
    logic [RET_W-1:0] retired;

    multicycle_control #(.WIDTH(32), .ALU_CTRL_W(3), .RET_W(RET_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
        .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [13:0] obs;
    assign obs = {imem_req, dmem_req, MemWrite, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc,
                  ALUctrl, ImmSrc, ResultSrc};

    localparam logic [13:0] IREQ = 14'h2000, DREQ = 14'h1000, MW = 14'h0800, IRW = 14'h0400,
                            PCW = 14'h0200, PCS = 14'h0100, RW = 14'h0080, ASRC = 14'h0040,
                            RS = 14'h0001;
    localparam logic [13:0] M_ALL = 14'h3FFF, M_CTL = 14'h3F80, M_WB = 14'h3F81,
                            M_EXR = 14'h3FF8, M_EXI = 14'h3FFE, M_EXB = 14'h3FBE;

    typedef enum {K_R, K_I, K_BEQ, K_BNE, K_LW, K_SW, K_BAD} kind_t;

    int total = 0, bad = 0, ret_m = 0;
    logic [13:0] qe[$], qm[$];
    logic        qi[$], qd[$], ql[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    function automatic logic [13:0] alu(input logic [2:0] a);
        return {8'd0, a, 3'd0};
    endfunction

    function automatic logic [13:0] imm(input logic [1:0] i);
        return {11'd0, i, 1'b0};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Mnemonic-level classification of the supported subset, with the ALU op each one needs.
    function automatic void model(input logic [31:0] w, output kind_t k, output logic [2:0] a);
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        logic [2:0] fa = 3'd0;
        logic       fok = 1'b1;
        k = K_BAD;
        a = 3'd0;
        case (f3)
            3'd0: fa = 3'd0;   // add
            3'd7: fa = 3'd2;   // and
            3'd6: fa = 3'd3;   // or
            3'd2: fa = 3'd5;   // slt
            default: fok = 1'b0;
        endcase
        case (w[6:0])
            7'h13: if (fok) begin k = K_I; a = fa; end
            7'h33: begin
                if (f7 == 7'h00 && fok) begin k = K_R; a = fa; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin k = K_R; a = 3'd1; end
            end
            7'h63: if (f3 == 3'd0) k = K_BEQ; else if (f3 == 3'd1) k = K_BNE;
            7'h03: if (f3 == 3'd2) k = K_LW;
            7'h23: if (f3 == 3'd2) k = K_SW;
            default: k = K_BAD;
        endcase
    endfunction

    function automatic logic [31:0] gen_legal();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 12);
        case (k)
            0:  begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
            1:  begin w[6:0] = 7'h13; w[14:12] = 3'd7; end
            2:  begin w[6:0] = 7'h13; w[14:12] = 3'd6; end
            3:  begin w[6:0] = 7'h13; w[14:12] = 3'd2; end
            4:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
            5:  begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
            6:  begin w[6:0] = 7'h33; w[14:12] = 3'd7; w[31:25] = 7'h00; end
            7:  begin w[6:0] = 7'h33; w[14:12] = 3'd6; w[31:25] = 7'h00; end
            8:  begin w[6:0] = 7'h33; w[14:12] = 3'd2; w[31:25] = 7'h00; end
            9:  begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
            10: begin w[6:0] = 7'h63; w[14:12] = 3'd1; end
            11: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
            default: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
        endcase
        return w;
    endfunction

    function automatic logic [31:0] gen_bad();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: begin w[6:0] = 7'h13; w[14:12] = 3'd1; end                  // slli
            1: begin w[6:0] = 7'h33; w[14:12] = 3'd7; w[31:25] = 7'h20; end
            2: begin w[6:0] = 7'h03; w[14:12] = 3'd0; end                  // lb
            3: begin w[6:0] = 7'h63; w[14:12] = 3'd4; end                  // blt
            default: w[6:0] = 7'h7F;
        endcase
        return w;
    endfunction

    task automatic push(input logic [13:0] e, input logic [13:0] m, input logic ia, input logic da,
                        input logic il);
        qe.push_back(e); qm.push_back(m); qi.push_back(ia); qd.push_back(da); ql.push_back(il);
    endtask

    // Builds the expected per-cycle trace of one instruction, then drives and checks it.
    task automatic run(input logic [31:0] w, input logic eq, input int iw, input int dw,
                       input string tag);
        kind_t k;
        logic [2:0] a;
        logic nz, retires;
        model(w, k, a);
        nz = (w[11:7] != 5'd0);
        retires = 1'b1;
        qe.delete(); qm.delete(); qi.delete(); qd.delete(); ql.delete();
        for (int i = 0; i < iw; i++) push(IREQ, M_CTL, 1'b0, rb(), 1'b0);
        push(IREQ | IRW, M_CTL, 1'b1, rb(), 1'b0);
        case (k)
            K_BAD: begin
`ifdef ILLEGAL_TRAP_EN
                retires = 1'b0;
                push(14'd0, M_CTL, rb(), rb(), 1'b0);
                for (int i = 0; i < 4; i++) push(14'd0, M_ALL, rb(), rb(), 1'b1);
`else
                push(PCW, M_CTL, rb(), rb(), 1'b0);
`endif
            end
            K_R, K_I: begin
                push(14'd0, M_CTL, rb(), rb(), 1'b0);
                if (k == K_I) push(alu(a) | ASRC, M_EXI, rb(), rb(), 1'b0);
                else          push(alu(a), M_EXR, rb(), rb(), 1'b0);
                push(PCW | (nz ? RW : 14'd0), M_WB, rb(), rb(), 1'b0);
            end
            K_BEQ, K_BNE: begin
                push(14'd0, M_CTL, rb(), rb(), 1'b0);
                push(PCW | alu(3'd1) | imm(2'd2) |
                     (((k == K_BEQ) == eq) ? PCS : 14'd0), M_EXB, rb(), rb(), 1'b0);
            end
            default: begin
                push(14'd0, M_CTL, rb(), rb(), 1'b0);
                push(ASRC | alu(3'd0) | imm((k == K_SW) ? 2'd1 : 2'd0), M_EXI, rb(), rb(), 1'b0);
                for (int i = 0; i < dw; i++)
                    push(DREQ | ((k == K_SW) ? MW : 14'd0), M_CTL, rb(), 1'b0, 1'b0);
                push(DREQ | ((k == K_SW) ? (MW | PCW) : 14'd0), M_CTL, rb(), 1'b1, 1'b0);
                if (k == K_LW) push(PCW | RS | (nz ? RW : 14'd0), M_WB, rb(), rb(), 1'b0);
            end
        endcase
        instr = w;
        EQ = eq;
        for (int c = 0; c < qe.size(); c++) begin
            imem_ack = qi[c];
            dmem_ack = qd[c];
            @(negedge clk);
            if (c == 0) chk({tag, ":retired"}, 32'(retired), 32'(ret_m));
            chk($sformatf("%s:c%0d", tag, c + 1), 32'(obs & qm[c]), 32'(qe[c] & qm[c]));
            chk($sformatf("%s:ill%0d", tag, c + 1), 32'(illegal), 32'(ql[c]));
            @(posedge clk);
            #1;
        end
        if (retires) ret_m = (ret_m + 1) % (1 << RET_W);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; EQ = 1'b0; instr = 32'h0000A283;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset:outs", 32'(obs), 32'd0);
        chk("reset:retired", 32'(retired), 32'd0);
        chk("reset:illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run(32'h00500093, 1'b0, 0, 0, "addi");
        run(32'h402081B3, 1'b0, 0, 0, "sub");
        run(32'h00209463, 1'b0, 0, 0, "bne_ne");
        run(32'h00209463, 1'b1, 0, 0, "bne_eq");
        run(32'h00208463, 1'b1, 0, 0, "beq_eq");
        run(32'h0000A283, 1'b0, 2, 3, "lw");
        run(32'h0000A003, 1'b0, 0, 3, "lw_x0");
        run(32'h0020A023, 1'b0, 1, 2, "sw");
`ifndef ILLEGAL_TRAP_EN
        run(32'h0000007F, 1'b0, 0, 0, "opc7f");
`endif
        for (int n = 0; n < 60; n++) begin
`ifdef ILLEGAL_TRAP_EN
            w = gen_legal();
`else
            w = ($urandom_range(0, 5) == 0) ? gen_bad() : gen_legal();
`endif
            run(w, rb(), $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        // Async reset in the middle of a load's data wait.
        instr = 32'h0000A283; EQ = 1'b0; dmem_ack = 1'b0;
        imem_ack = 1'b1; @(posedge clk); #1;
        imem_ack = 1'b0; repeat (2) @(posedge clk); #1;
        @(negedge clk);
        chk("midmem:dreq_before", 32'(dmem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midmem:dreq_after", 32'(dmem_req), 32'd0);
        chk("midmem:outs", 32'(obs), 32'd0);
        chk("midmem:retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        ret_m = 0;

        // Walk the counter to its top value and across the wrap.
        for (int n = 0; n < (1 << RET_W) + 1; n++)
            run(32'h00100113, 1'b0, 0, 0, $sformatf("wrap%0d", n));
        @(negedge clk);
        chk("wrap:final", 32'(retired), 32'(ret_m));

`ifdef ILLEGAL_TRAP_EN
        run(32'h0000007F, 1'b0, 0, 0, "trap");
        rst = 1'b0;
        #1;
        chk("trap:cleared", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
